byte_serial_accumulator: RTL and testbench



---
 rtl/byte_serial_accumulator.sv | 154 +++++++++++++++
 tb/tb_byte_serial_accumulator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_accumulator.sv
// rtl/byte_serial_accumulator.sv - byte-serial signed accumulator driving an external 8-bit CLA
//
// Purpose: sums N_TERMS signed 8-bit product terms into a 16-bit two's-complement
// result. Each term takes two passes through the external adder: the low byte
// first, then the sign-extended high byte with the low-byte carry fed back in.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     in_data is presented
//   in_ready     block can accept a term (decoded from state only)
//   in_data      signed 8-bit product term
//   adder_a      CLA operand A
//   adder_b      CLA operand B
//   adder_cin    CLA carry-in
//   adder_s      CLA sum (combinational from adder_a/adder_b/adder_cin)
//   adder_carry  CLA carry-out
//   sum_valid    one-cycle pulse; sum_data/sum_ovf valid
//   sum_data     signed accumulated sum, held until the next sum_valid
//   sum_ovf      sticky signed overflow seen during this sum
module byte_serial_accumulator #(
  parameter int N_TERMS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [7:0]  adder_a,
  output logic [7:0]  adder_b,
  output logic        adder_cin,
  input  logic [7:0]  adder_s,
  input  logic        adder_carry,
  output logic        sum_valid,
  output logic [15:0] sum_data,
  output logic        sum_ovf
);

  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [15:0]     r_acc;
  logic [7:0]      r_x;
  logic            r_c;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic [15:0]     r_sum_data;
  logic            r_sum_ovf;

  logic            w_last;
  logic            w_ovf_term;

  assign w_last = (r_cnt == LAST_CNT);

  // Signed overflow of the full 16-bit add shows up in the top byte: operands
  // agree in sign but the result does not.
  assign w_ovf_term = (adder_a[7] == adder_b[7]) & (adder_s[7] != adder_a[7]);

  assign sum_data = r_sum_data;
  assign sum_ovf  = r_sum_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    sum_valid    = 1'b0;
    adder_a      = 8'h00;
    adder_b      = 8'h00;
    adder_cin    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = S_LOW;
        end
      end
      S_LOW: begin
        adder_a      = r_acc[7:0];
        adder_b      = r_x;
        w_next_state = S_HIGH;
      end
      S_HIGH: begin
        adder_a      = r_acc[15:8];
        adder_b      = {8{r_x[7]}};
        adder_cin    = r_c;
        w_next_state = w_last ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        sum_valid    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= 16'h0000;
      r_x        <= 8'h00;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_sum_data <= 16'h0000;
      r_sum_ovf  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x <= in_data;
          end
        end
        S_LOW: begin
          r_acc[7:0] <= adder_s;
          r_c        <= adder_carry;
        end
        S_HIGH: begin
          if (w_last) begin
            // Publish the finished sum and start the next one from zero.
            r_sum_data <= {adder_s, r_acc[7:0]};
            r_sum_ovf  <= r_ovf | w_ovf_term;
            r_acc      <= 16'h0000;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
          end else begin
            r_acc[15:8] <= adder_s;
            r_cnt       <= r_cnt + CW'(1);
            r_ovf       <= r_ovf | w_ovf_term;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_accumulator.sv
// tb/tb_byte_serial_accumulator.sv - bench for byte_serial_accumulator (N_TERMS = 4, 300, 1)
module tb_byte_serial_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N_TERMS = 4 instance
  logic        iv4, rdy4, ci4, ac4, sv4, ovf4;
  logic [7:0]  d4, aa4, ab4, as4;
  logic [15:0] sum4;
  assign {ac4, as4} = 9'(aa4) + 9'(ab4) + 9'(ci4);

  byte_serial_accumulator #(.N_TERMS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .in_data(d4),
    .adder_a(aa4), .adder_b(ab4), .adder_cin(ci4), .adder_s(as4), .adder_carry(ac4),
    .sum_valid(sv4), .sum_data(sum4), .sum_ovf(ovf4)
  );

  // N_TERMS = 300 instance
  logic        ivk, rdyk, cik, ack, svk, ovfk;
  logic [7:0]  dk, aak, abk, ask;
  logic [15:0] sumk;
  assign {ack, ask} = 9'(aak) + 9'(abk) + 9'(cik);

  byte_serial_accumulator #(.N_TERMS(300)) u_dut300 (
    .clk(clk), .rst(rst), .in_valid(ivk), .in_ready(rdyk), .in_data(dk),
    .adder_a(aak), .adder_b(abk), .adder_cin(cik), .adder_s(ask), .adder_carry(ack),
    .sum_valid(svk), .sum_data(sumk), .sum_ovf(ovfk)
  );

  // N_TERMS = 1 instance
  logic        iv1, rdy1, ci1, ac1, sv1, ovf1;
  logic [7:0]  d1, aa1, ab1, as1;
  logic [15:0] sum1;
  assign {ac1, as1} = 9'(aa1) + 9'(ab1) + 9'(ci1);

  byte_serial_accumulator #(.N_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_data(d1),
    .adder_a(aa1), .adder_b(ab1), .adder_cin(ci1), .adder_s(as1), .adder_carry(ac1),
    .sum_valid(sv1), .sum_data(sum1), .sum_ovf(ovf1)
  );

  logic [15:0] held4;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed sum of terms, wrapped to 16 bits, flag if any true partial sum leaves int16 range.
  function automatic void mdl_add(inout logic [15:0] acc, inout logic ovf, input logic [7:0] t);
    int s;
    s = int'($signed(acc)) + int'($signed(t));
    if (s > 32767 || s < -32768) ovf = 1'b1;
    acc = s[15:0];
  endfunction

  task automatic push4(input logic [7:0] d);
    int n = 0;
    while (!rdy4 && n < 20) begin step(); n++; end
    if (n >= 20) chk("push4_timeout", 16'(rdy4), 16'd1);
    iv4 = 1'b1; d4 = d;
    step();
    iv4 = 1'b0; d4 = 8'($urandom);
  endtask

  task automatic pushk(input logic [7:0] d);
    int n = 0;
    while (!rdyk && n < 20) begin step(); n++; end
    if (n >= 20) chk("pushk_timeout", 16'(rdyk), 16'd1);
    ivk = 1'b1; dk = d;
    step();
    ivk = 1'b0; dk = 8'($urandom);
  endtask

  task automatic run_sum4(input logic [7:0] t [4], input bit gaps);
    logic [15:0] acc;
    logic        ovf;
    logic        cin_e;
    acc = 16'h0000; ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      push4(t[i]);
      chk("low_a", 16'(aa4), 16'(acc[7:0]));
      chk("low_b", 16'(ab4), 16'(t[i]));
      chk("low_cin", 16'(ci4), 16'd0);
      chk("low_rdy", 16'(rdy4), 16'd0);
      cin_e = (9'(acc[7:0]) + 9'(t[i])) > 9'h0FF;
      step();
      chk("high_a", 16'(aa4), 16'(acc[15:8]));
      chk("high_b", 16'(ab4), 16'({8{t[i][7]}}));
      chk("high_cin", 16'(ci4), 16'(cin_e));
      mdl_add(acc, ovf, t[i]);
      step();
      if (i == 3) begin
        chk("done_valid", 16'(sv4), 16'd1);
        chk("done_rdy", 16'(rdy4), 16'd0);
        chk("done_data", sum4, acc);
        chk("done_ovf", 16'(ovf4), 16'(ovf));
        held4 = acc;
        step();
        chk("after_valid", 16'(sv4), 16'd0);
        chk("after_rdy", 16'(rdy4), 16'd1);
      end else begin
        chk("mid_rdy", 16'(rdy4), 16'd1);
        chk("mid_valid", 16'(sv4), 16'd0);
        chk("held_data", sum4, held4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  tv [4];
    logic [7:0]  fr [$];
    logic [15:0] acc;
    logic        ovf;
    int          n;

    rst = 1'b1;
    iv4 = 1'b0; ivk = 1'b0; iv1 = 1'b0;
    d4 = 8'h00; dk = 8'h00; d1 = 8'h00;
    held4 = 16'h0000;
    step(); step();
    chk("rst_rdy", 16'(rdy4), 16'd1);
    chk("rst_valid", 16'(sv4), 16'd0);
    chk("rst_data", sum4, 16'h0000);
    chk("rst_ovf", 16'(ovf4), 16'd0);
    chk("rst_a", 16'(aa4), 16'd0);
    chk("rst_b", 16'(ab4), 16'd0);
    chk("rst_cin", 16'(ci4), 16'd0);
    rst = 1'b0;
    step();

    // Directed sums
    tv = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_sum4(tv, 1'b0);
    chk("sum_1234", sum4, 16'h000A);
    tv = '{8'hFF, 8'hFF, 8'h01, 8'h80};
    run_sum4(tv, 1'b0);
    chk("sum_neg", sum4, 16'hFF7F);
    chk("sum_neg_ovf", 16'(ovf4), 16'd0);
    tv = '{8'h7F, 8'h7F, 8'h7F, 8'h01};
    run_sum4(tv, 1'b1);
    chk("sum_carry", sum4, 16'h017E);

    // Random sums with random idle gaps
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) tv[i] = 8'($urandom);
      run_sum4(tv, 1'b1);
    end

    // in_valid held high: two back-to-back sums, 13-cycle frame
    iv4 = 1'b1; d4 = 8'($urandom);
    for (int c = 0; c < 26; c++) begin
      int  p;
      bit  er, es;
      p  = c % 13;
      er = (p < 12) && (p % 3 == 0);
      es = (p == 12);
      chk("stream_rdy", 16'(rdy4), 16'(er));
      chk("stream_valid", 16'(sv4), 16'(es));
      if (es) begin
        acc = 16'h0000; ovf = 1'b0;
        foreach (fr[j]) mdl_add(acc, ovf, fr[j]);
        chk("stream_data", sum4, acc);
        chk("stream_ovf", 16'(ovf4), 16'(ovf));
        fr.delete();
      end
      if (er) fr.push_back(d4);
      step();
      d4 = 8'($urandom);
    end
    iv4 = 1'b0;
    step();

    // Reset mid-sum: asserted while the second term is in HIGH
    push4(8'h33);
    step(); step();
    push4(8'h44);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 16'(rdy4), 16'd1);
    chk("mid_rst_valid", 16'(sv4), 16'd0);
    chk("mid_rst_data", sum4, 16'h0000);
    chk("mid_rst_ovf", 16'(ovf4), 16'd0);
    chk("mid_rst_a", 16'(aa4), 16'd0);
    chk("mid_rst_b", 16'(ab4), 16'd0);
    chk("mid_rst_cin", 16'(ci4), 16'd0);
    #2;
    rst = 1'b0;
    held4 = 16'h0000;
    step();
    tv = '{8'd5, 8'd5, 8'd5, 8'd5};
    run_sum4(tv, 1'b0);
    chk("post_rst_sum", sum4, 16'h0014);

    // N_TERMS = 300: wrap and sticky overflow, then an all-zero sum
    for (int s = 0; s < 2; s++) begin
      logic [7:0] tt;
      tt = (s == 0) ? 8'h7F : 8'h00;
      for (int i = 0; i < 300; i++) pushk(tt);
      n = 0;
      while (!svk && n < 6) begin step(); n++; end
      chk("k_valid", 16'(svk), 16'd1);
      chk("k_data", sumk, (s == 0) ? 16'h94D4 : 16'h0000);
      chk("k_ovf", 16'(ovfk), (s == 0) ? 16'd1 : 16'd0);
      step();
    end

    // N_TERMS = 1: every term is a complete sum
    for (int i = 0; i < 6; i++) begin
      logic [7:0] t1;
      t1 = 8'($urandom);
      n = 0;
      while (!rdy1 && n < 10) begin step(); n++; end
      iv1 = 1'b1; d1 = t1;
      step();
      iv1 = 1'b0;
      step(); step();
      chk("one_valid", 16'(sv1), 16'd1);
      chk("one_data", sum1, {{8{t1[7]}}, t1});
      chk("one_ovf", 16'(ovf1), 16'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
